// File: rtl/tb_pkg.sv
// Shared types and defaults for run_controller: FSM state encoding and CLEAR-length default.
package tb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_RUN   = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    localparam int unsigned RESET_CYCLES_DEF = 4;

    function automatic logic is_busy(input state_e s);
        return (s == ST_CLEAR) || (s == ST_RUN) || (s == ST_DRAIN);
    endfunction

endpackage

// File: rtl/cycle_counter.sv
// Loadable down-counter with zero flag; times the CLEAR and DRAIN phases of run_controller.
module cycle_counter #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_dec,
    output logic         o_zero_c
);

    logic [W-1:0] r_count;

    // Load wins over decrement; decrement stops at zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - W'(1);
        end
    end

    assign o_zero_c = (r_count == '0);

endmodule

// File: rtl/run_controller.sv
// Run sequencer for the HPC test datapath: IDLE -> CLEAR -> RUN -> DRAIN -> DONE.
// Optional early stop on scoreboard event limit: define RUN_CONTROLLER_STOP_ON_EVENT_EN.
module run_controller
    import tb_pkg::*;
#(
    parameter int unsigned WIDTH        = 32,
    parameter int unsigned DRAIN_W      = 8,
    parameter int unsigned RESET_CYCLES = RESET_CYCLES_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               i_start,
    input  logic               i_abort,
    input  logic [WIDTH-1:0]   i_num_samples,
    input  logic [DRAIN_W-1:0] i_drain_cycles,
    input  logic [WIDTH-1:0]   i_event_ctr,
    input  logic [WIDTH-1:0]   i_event_limit,
    output logic               o_hpc_reset,
    output logic               o_hpc_enable,
    output logic               o_busy,
    output logic               o_done,
    output logic               o_aborted,
    output logic               o_early_stop,
    output logic [WIDTH-1:0]   o_sample_ctr
);

    localparam int unsigned CNT_W = (DRAIN_W > 8) ? DRAIN_W : 8;

    state_e             r_state;
    state_e             w_next;

    logic [WIDTH-1:0]   r_num;
    logic [DRAIN_W-1:0] r_drain;
    logic [WIDTH-1:0]   r_limit;

    logic               r_hpc_reset;
    logic               r_hpc_enable;
    logic               r_busy;
    logic               r_done;
    logic               r_aborted;
    logic               r_early_stop;
    logic [WIDTH-1:0]   r_sample_ctr;

    logic               w_latch;
    logic               w_aborted;
    logic               w_early_stop;
    logic [WIDTH-1:0]   w_sample_ctr;
    logic               w_cnt_load;
    logic [CNT_W-1:0]   w_cnt_val;
    logic               w_cnt_dec;
    logic               w_cnt_zero;
    logic               w_stop_hit;

`ifdef RUN_CONTROLLER_STOP_ON_EVENT_EN
    assign w_stop_hit = (r_limit != '0) && (i_event_ctr >= r_limit);
`else
    logic w_unused_event;
    assign w_stop_hit     = 1'b0;
    assign w_unused_event = ^{i_event_ctr, r_limit};
`endif

    cycle_counter #(
        .W (CNT_W)
    ) u_phase_ctr (
        .clk        (clk),
        .reset      (reset),
        .i_load     (w_cnt_load),
        .i_load_val (w_cnt_val),
        .i_dec      (w_cnt_dec),
        .o_zero_c   (w_cnt_zero)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next state plus next values of the registered outputs; abort has top priority.
    always_comb begin
        w_next       = r_state;
        w_latch      = 1'b0;
        w_aborted    = r_aborted;
        w_early_stop = r_early_stop;
        w_sample_ctr = r_sample_ctr;
        w_cnt_load   = 1'b0;
        w_cnt_val    = '0;
        w_cnt_dec    = 1'b0;

        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (i_abort) begin
                    w_next = ST_IDLE;
                end else if (i_start) begin
                    w_next       = ST_CLEAR;
                    w_latch      = 1'b1;
                    w_aborted    = 1'b0;
                    w_early_stop = 1'b0;
                    w_sample_ctr = '0;
                    w_cnt_load   = 1'b1;
                    w_cnt_val    = CNT_W'(RESET_CYCLES - 1);
                end
            end
            ST_CLEAR: begin
                if (i_abort) begin
                    w_next    = ST_IDLE;
                    w_aborted = 1'b1;
                end else if (w_cnt_zero) begin
                    if (r_num == '0) begin
                        w_next     = ST_DRAIN;
                        w_cnt_load = 1'b1;
                        w_cnt_val  = CNT_W'(r_drain);
                    end else begin
                        w_next = ST_RUN;
                    end
                end else begin
                    w_cnt_dec = 1'b1;
                end
            end
            ST_RUN: begin
                if (i_abort) begin
                    w_next    = ST_IDLE;
                    w_aborted = 1'b1;
                end else if (w_stop_hit || (r_sample_ctr >= r_num)) begin
                    w_next       = ST_DRAIN;
                    w_early_stop = r_early_stop | w_stop_hit;
                    w_cnt_load   = 1'b1;
                    w_cnt_val    = CNT_W'(r_drain);
                end
            end
            ST_DRAIN: begin
                if (i_abort) begin
                    w_next    = ST_IDLE;
                    w_aborted = 1'b1;
                end else if (w_cnt_zero) begin
                    w_next = ST_DONE;
                end else begin
                    w_cnt_dec = 1'b1;
                end
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase

        // Counter reflects the RUN cycle being entered, so it equals enabled cycles issued.
        if ((w_next == ST_RUN) && (r_sample_ctr != '1)) begin
            w_sample_ctr = r_sample_ctr + WIDTH'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_num   <= '0;
            r_drain <= '0;
            r_limit <= '0;
        end else if (w_latch) begin
            r_num   <= i_num_samples;
            r_drain <= i_drain_cycles;
            r_limit <= i_event_limit;
        end
    end

    // Moore outputs decoded from the next state and registered.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hpc_reset  <= 1'b1;
            r_hpc_enable <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_aborted    <= 1'b0;
            r_early_stop <= 1'b0;
            r_sample_ctr <= '0;
        end else begin
            r_hpc_reset  <= (w_next == ST_IDLE) || (w_next == ST_CLEAR);
            r_hpc_enable <= (w_next == ST_RUN);
            r_busy       <= is_busy(w_next);
            r_done       <= (w_next == ST_DONE);
            r_aborted    <= w_aborted;
            r_early_stop <= w_early_stop;
            r_sample_ctr <= w_sample_ctr;
        end
    end

    assign o_hpc_reset  = r_hpc_reset;
    assign o_hpc_enable = r_hpc_enable;
    assign o_busy       = r_busy;
    assign o_done       = r_done;
    assign o_aborted    = r_aborted;
    assign o_early_stop = r_early_stop;
    assign o_sample_ctr = r_sample_ctr;

endmodule
